// File: rtl/sfi_pkg.sv
// sfi_pkg: shared types and defaults for the sfi_guard address guard.
//   region_t    : one sandbox region entry (base, mask, enable). Base and mask
//                 are held at the maximum supported width and zero-extended
//                 from ADDR_W, so a single packed type serves every instance.
//   fault_st_t  : sticky fault state machine encoding (OK / FAULTED).
//   *_DEF       : default parameter values for sfi_guard.
//   idx_width() : region index width, never less than 1 bit.
package sfi_pkg;

  localparam int SFI_MAX_ADDR_W      = 64;
  localparam int SFI_ADDR_W_DEF      = 64;
  localparam int SFI_NUM_REGIONS_DEF = 4;
  localparam int SFI_CNT_W_DEF       = 16;

  typedef struct packed {
    logic [SFI_MAX_ADDR_W-1:0] base;
    logic [SFI_MAX_ADDR_W-1:0] mask;
    logic                      en;
  } region_t;

  typedef enum logic {
    SFI_OK      = 1'b0,
    SFI_FAULTED = 1'b1
  } fault_st_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sfi_region_match.sv
// sfi_region_match: purely combinational region hit detection.
//   i_table : region table (base/mask/en per region)
//   i_addr  : address under test
//   o_hit   : one bit per region, set when the region is enabled and the
//             address agrees with the base on every bit selected by the mask
module sfi_region_match
  import sfi_pkg::*;
#(
  parameter int ADDR_W      = SFI_ADDR_W_DEF,
  parameter int NUM_REGIONS = SFI_NUM_REGIONS_DEF
) (
  input  region_t [NUM_REGIONS-1:0] i_table,
  input  logic    [ADDR_W-1:0]      i_addr,
  output logic    [NUM_REGIONS-1:0] o_hit
);

  logic [SFI_MAX_ADDR_W-1:0] w_addr;

  // Table entries are stored zero-extended, so the extended address compares
  // cleanly on the unused upper bits.
  assign w_addr = SFI_MAX_ADDR_W'(i_addr);

  always_comb begin
    o_hit = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      o_hit[i] = i_table[i].en &&
                 ((w_addr & i_table[i].mask) == (i_table[i].base & i_table[i].mask));
    end
  end

endmodule

// File: rtl/sfi_guard.sv
// sfi_guard: registered multi-region software-fault-isolation address guard.
// Sits between effective-address generation and the memory request port.
// Legal addresses pass through; illegal ones are zeroed, flagged, latched into
// a sticky fault and counted. One output register with valid/ready handshake.
//
// Optional feature macro: SFI_VIOL_CNT_EN
//   defined   : viol_cnt and fault_addr are implemented
//   undefined : viol_cnt and fault_addr are tied to zero (no registers)
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   cfg_we/idx/base/mask/en region table write port (ignored while locked)
//   cfg_lock               pulse: lock the table until reset
//   in_valid/in_ready/ri   request handshake and effective address
//   out_valid/out_ready    result handshake
//   ro, out_fault          sanitised address and per-result violation flag
//   fault, fault_clr       sticky violation flag and its clear
//   fault_addr             first offending address since last clear
//   viol_cnt               saturating violation count
//   locked                 table lock status
module sfi_guard
  import sfi_pkg::*;
#(
  parameter int ADDR_W      = SFI_ADDR_W_DEF,
  parameter int NUM_REGIONS = SFI_NUM_REGIONS_DEF,
  parameter int IDX_W       = idx_width(NUM_REGIONS),
  parameter int CNT_W       = SFI_CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_mask,
  input  logic              cfg_en,
  input  logic              cfg_lock,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] ri,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] ro,
  output logic              out_fault,
  output logic              fault,
  input  logic              fault_clr,
  output logic [ADDR_W-1:0] fault_addr,
  output logic [CNT_W-1:0]  viol_cnt,
  output logic              locked
);

  region_t [NUM_REGIONS-1:0] r_table;
  logic                      r_locked;
  logic                      r_out_valid;
  logic [ADDR_W-1:0]         r_ro;
  logic                      r_out_fault;
  fault_st_t                 r_state;

  logic [NUM_REGIONS-1:0]    w_hit;
  logic                      w_legal;
  logic                      w_accept;
  logic                      w_viol;

  sfi_region_match #(
    .ADDR_W      (ADDR_W),
    .NUM_REGIONS (NUM_REGIONS)
  ) u_match (
    .i_table (r_table),
    .i_addr  (ri),
    .o_hit   (w_hit)
  );

  assign w_legal  = |w_hit;
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_viol   = w_accept && !w_legal;

  // Region table and lock. The match above reads r_table, so a write lands
  // after any request accepted in the same cycle has been checked. A write
  // coinciding with cfg_lock still completes because the lock is not yet set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_table  <= '0;
      r_locked <= 1'b0;
    end else begin
      if (cfg_we && !r_locked) begin
        for (int i = 0; i < NUM_REGIONS; i++) begin
          if (cfg_idx == IDX_W'(i)) begin
            r_table[i].base <= SFI_MAX_ADDR_W'(cfg_base);
            r_table[i].mask <= SFI_MAX_ADDR_W'(cfg_mask);
            r_table[i].en   <= cfg_en;
          end
        end
      end
      if (cfg_lock) begin
        r_locked <= 1'b1;
      end
    end
  end

  // Output stage: a new result loads on acceptance; a stalled result holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_ro        <= '0;
      r_out_fault <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_ro        <= w_legal ? ri : '0;
      r_out_fault <= !w_legal;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky fault state; a violation takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SFI_OK;
    end else begin
      case (r_state)
        SFI_OK: begin
          if (w_viol) r_state <= SFI_FAULTED;
        end
        SFI_FAULTED: begin
          if (fault_clr && !w_viol) r_state <= SFI_OK;
        end
        default: r_state <= SFI_OK;
      endcase
    end
  end

`ifdef SFI_VIOL_CNT_EN
  logic [CNT_W-1:0]  r_viol_cnt;
  logic [ADDR_W-1:0] r_fault_addr;

  // fault_addr follows the first violation since the last clear; a clear in
  // the same cycle as a violation re-arms capture for that violation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_viol_cnt   <= '0;
      r_fault_addr <= '0;
    end else if (w_viol) begin
      if (r_viol_cnt != '1) begin
        r_viol_cnt <= r_viol_cnt + 1'b1;
      end
      if ((r_state == SFI_OK) || fault_clr) begin
        r_fault_addr <= ri;
      end
    end
  end

  assign viol_cnt   = r_viol_cnt;
  assign fault_addr = r_fault_addr;
`else
  assign viol_cnt   = '0;
  assign fault_addr = '0;
`endif

  assign out_valid = r_out_valid;
  assign ro        = r_ro;
  assign out_fault = r_out_fault;
  assign fault     = (r_state == SFI_FAULTED);
  assign locked    = r_locked;

endmodule

// File: tb/tb_sfi_guard.sv
// tb_sfi_guard: directed self-checking bench for sfi_guard (CNT_W = 2 so the
// counter saturation is reachable). Inputs change 1 time unit after a rising
// edge; outputs are checked at that same point, away from the active edge.
module tb_sfi_guard;

  localparam int ADDR_W = 64;
  localparam int NREG   = 4;
  localparam int IDX_W  = 2;
  localparam int CNT_W  = 2;

`ifdef SFI_VIOL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  logic [ADDR_W-1:0] cfg_base;
  logic [ADDR_W-1:0] cfg_mask;
  logic              cfg_en;
  logic              cfg_lock;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] ri;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] ro;
  logic              out_fault;
  logic              fault;
  logic              fault_clr;
  logic [ADDR_W-1:0] fault_addr;
  logic [CNT_W-1:0]  viol_cnt;
  logic              locked;

  int n_checks = 0;
  int n_errors = 0;

  sfi_guard #(
    .ADDR_W      (ADDR_W),
    .NUM_REGIONS (NREG),
    .IDX_W       (IDX_W),
    .CNT_W       (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_base   (cfg_base),
    .cfg_mask   (cfg_mask),
    .cfg_en     (cfg_en),
    .cfg_lock   (cfg_lock),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ri         (ri),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ro         (ro),
    .out_fault  (out_fault),
    .fault      (fault),
    .fault_clr  (fault_clr),
    .fault_addr (fault_addr),
    .viol_cnt   (viol_cnt),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle request; result is visible on return.
  task automatic send(input logic [63:0] a);
    in_valid = 1'b1;
    ri       = a;
    step();
    in_valid = 1'b0;
  endtask

  function automatic logic [63:0] ec(input int v);
    return CNT_EN ? 64'(v) : 64'd0;
  endfunction

  function automatic logic [63:0] ea(input logic [63:0] a);
    return CNT_EN ? a : 64'd0;
  endfunction

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_base = '0; cfg_mask = '0;
    cfg_en = 1'b0; cfg_lock = 1'b0; in_valid = 1'b0; ri = '0;
    out_ready = 1'b1; fault_clr = 1'b0;
    step(); step();

    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ro", ro, 0);
    chk("rst_out_fault", out_fault, 0);
    chk("rst_fault", fault, 0);
    chk("rst_fault_addr", fault_addr, 0);
    chk("rst_viol_cnt", viol_cnt, 0);
    chk("rst_locked", locked, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    step();

    // Empty table: everything illegal
    send(64'hA2199872);
    chk("empty_out_valid", out_valid, 1);
    chk("empty_ro", ro, 0);
    chk("empty_out_fault", out_fault, 1);
    chk("empty_fault", fault, 1);
    chk("empty_viol_cnt", viol_cnt, ec(1));
    chk("empty_fault_addr", fault_addr, ea(64'hA2199872));

    // Write region0 while a request is accepted: request sees the old table
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_base = 64'hA2000000;
    cfg_mask = 64'hFF000000; cfg_en = 1'b1;
    send(64'hA2199872);
    cfg_we = 1'b0;
    chk("oldtbl_out_fault", out_fault, 1);
    chk("oldtbl_ro", ro, 0);
    chk("oldtbl_viol_cnt", viol_cnt, ec(2));
    chk("oldtbl_fault_addr", fault_addr, ea(64'hA2199872));

    send(64'hA2199872);
    chk("legal_ro", ro, 64'hA2199872);
    chk("legal_out_fault", out_fault, 0);
    chk("legal_fault_sticky", fault, 1);
    chk("legal_viol_cnt", viol_cnt, ec(2));

    send(64'h00FFEEDD);
    chk("illegal_ro", ro, 0);
    chk("illegal_out_fault", out_fault, 1);
    chk("illegal_viol_cnt", viol_cnt, ec(3));
    chk("illegal_fault_addr_held", fault_addr, ea(64'hA2199872));

    // Clear, then new first violation, then clear+violation together
    fault_clr = 1'b1; step(); fault_clr = 1'b0;
    chk("clr_fault", fault, 0);
    send(64'h11110000);
    chk("v4_fault", fault, 1);
    chk("v4_fault_addr", fault_addr, ea(64'h11110000));
    fault_clr = 1'b1;
    send(64'h22220000);
    fault_clr = 1'b0;
    chk("clrviol_fault", fault, 1);
    chk("clrviol_fault_addr", fault_addr, ea(64'h22220000));
    send(64'h33330000);
    chk("v6_fault_addr_held", fault_addr, ea(64'h22220000));
    chk("sat_viol_cnt", viol_cnt, ec(3));

    // Back-pressure
    step();
    chk("drain_out_valid", out_valid, 0);
    out_ready = 1'b0;
    send(64'hA2000001);
    in_valid = 1'b1; ri = 64'hA2000002;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_ro", ro, 64'hA2000001);
      step();
    end
    chk("bp_ro_end", ro, 64'hA2000001);
    out_ready = 1'b1;
    step();
    chk("bp_release_ro", ro, 64'hA2000002);

    // Stream 8 back-to-back
    for (int i = 0; i < 8; i++) begin
      ri = 64'hA2000100 + 64'(i);
      step();
      chk("stream_valid", out_valid, 1);
      chk("stream_ro", ro, 64'hA2000100 + 64'(i));
    end
    in_valid = 1'b0;
    step();

    // Write together with lock completes, later writes are ignored
    cfg_we = 1'b1; cfg_idx = 2'd1; cfg_base = 64'h50000000;
    cfg_mask = 64'hF0000000; cfg_en = 1'b1; cfg_lock = 1'b1;
    step();
    cfg_we = 1'b0; cfg_lock = 1'b0;
    chk("lock_set", locked, 1);
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_base = '0; cfg_mask = '0; cfg_en = 1'b0;
    step();
    cfg_we = 1'b0;
    send(64'hA2199872);
    chk("locked_r0_ro", ro, 64'hA2199872);
    chk("locked_r0_fault", out_fault, 0);
    send(64'h50001234);
    chk("lockwr_r1_ro", ro, 64'h50001234);
    chk("lockwr_r1_fault", out_fault, 0);
    send(64'h00000010);
    chk("locked_miss_fault", out_fault, 1);
    chk("locked_miss_ro", ro, 0);
    chk("locked_still", locked, 1);
    chk("locked_viol_cnt", viol_cnt, ec(3));

    // Asynchronous reset with a result pending
    out_ready = 1'b0;
    send(64'hA2199872);
    chk("prerst_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_ro", ro, 0);
    chk("arst_out_fault", out_fault, 0);
    chk("arst_fault", fault, 0);
    chk("arst_fault_addr", fault_addr, 0);
    chk("arst_viol_cnt", viol_cnt, 0);
    chk("arst_locked", locked, 0);
    chk("arst_in_ready", in_ready, 1);
    step();
    rst_n = 1'b1; out_ready = 1'b1;
    step();
    chk("post_rst_no_stale", out_valid, 0);
    send(64'hA2199872);
    chk("post_rst_tbl_cleared", out_fault, 1);
    chk("post_rst_ro", ro, 0);
    chk("post_rst_viol_cnt", viol_cnt, ec(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
